row_drain_mdl: RTL
==================

Name: row_drain_mdl

Overview:
- Parallel-to-row serializer; the transmit-side counterpart of the row buffer that packs incoming rows into a wide block.
- Captures a full ROWS x ROW_W block in one cycle and emits it one row per cycle to a downstream consumer over a valid/ready handshake.
- Flags the last row and signals completion.
- Sits at the matrix core output, draining wide result blocks back onto the 1024-bit row bus.

Parameters:
- ROW_W, 1024, bits per row.
- ROWS, 64, rows per block; power of two, >= 2.
- IDX_W, 6, row index width; equals log2(ROWS).

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  drain enable; low pauses emission.
- load  in  1  capture request for dats.
- dats  in  ROWS*ROW_W  block; row k = dats[k*ROW_W +: ROW_W].
- ready  in  1  downstream accepts datsOut this cycle.
- valid  out  1  datsOut holds a valid row.
- datsOut  out  ROW_W  current row.
- rowIdx  out  IDX_W  index of the row on datsOut.
- dendFlag  out  1  high while the presented row is row ROWS-1.
- busy  out  1  block held, drain in progress.
- doneFlag  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset: when reset==0 at a clock edge, the FSM goes to IDLE and the shadow register and counter clear. valid, busy, dendFlag, doneFlag, rowIdx and datsOut all go to 0. Reset wins over every other input, including mid-drain; a partially sent block is discarded.
- FSM has two states: IDLE and SEND.
- IDLE:
  - busy=0, valid=0.
  - load=1 at edge t: shadow<=dats, cnt<=0, state<=SEND.
  - At t+1: busy=1; valid=enable; datsOut=row0; rowIdx=0.
  - Load-to-first-row latency is one cycle.
- SEND:
  - busy=1; valid = enable.
  - datsOut = shadow[ROW_W-1:0], which is the row at index cnt.
  - rowIdx = cnt; dendFlag = valid && (cnt==ROWS-1).
- Handshake:
  - A row is transferred on any edge where valid && ready.
  - On transfer with cnt<ROWS-1: shadow shifts right by ROW_W, cnt increments, and the next row appears on the following cycle. Throughput is 1 row/cycle back-to-back.
  - ready low with valid high: datsOut, rowIdx and dendFlag hold stable until accepted.
  - enable low: valid=0 and no transfer, regardless of ready. State, cnt and shadow hold. Emission resumes at the same row when enable returns high.
- Last row: a transfer with cnt==ROWS-1 sends state<=IDLE and cnt<=0. doneFlag=1 for exactly the next cycle, along with busy=0 and valid=0.
- load during SEND is ignored; the shadow is not overwritten. load on the same edge as the last-row transfer is also ignored, because the state is still SEND when it is sampled. A new load is accepted from IDLE on the following cycle or later.
- load during IDLE with enable=0: the block is captured, but valid stays 0 until enable rises.
- datsOut is 0 in IDLE. No X on any output after reset.
- The counter never wraps mid-block: cnt runs 0..ROWS-1, then returns to 0 only via the IDLE transition.

Test Plan:
- ROW_W=8, ROWS=4; reset low 2 cycles, then high -> all outputs 0. busy=0, valid=0.
- load dats=32'h44332211, ready=1, enable=1 -> valid high from the next cycle. datsOut sequence is 11,22,33,44 on consecutive cycles with rowIdx 0..3. dendFlag is high only with 44. doneFlag pulses the cycle after 44; busy=0 on that cycle.
- Same load, with ready toggling 1,0,0,1,1,0,1 -> each row is held stable while ready=0. Exactly 4 transfers occur, in order, with no duplicate and no skip.
- Mid-drain, after row 22 is accepted, drop enable for 3 cycles -> valid=0 and datsOut/rowIdx hold. On re-enable, 33 is presented with rowIdx=2.
- During SEND, assert load with dats=32'hDDCCBBAA, including on the final transfer edge -> the original rows 11..44 are output unchanged. A load one cycle after doneFlag then outputs AA..DD.
- Assert reset low after row 11 is accepted -> next cycle all outputs are 0 and state is IDLE. A new load restarts at rowIdx=0.
- Default params: load a 65536-bit block with row k = {16{k[5:0],58'h0}}, ready=1 -> 64 rows in 64 consecutive cycles. dendFlag is high on rowIdx=63.

Source files
------------

// File: rtl/row_drain_mdl.sv
// Parallel-to-row serializer: captures a ROWS x ROW_W block in one cycle and
// emits it one row per cycle over a valid/ready handshake.
module row_drain_mdl #(
  parameter int unsigned ROW_W = 1024,
  parameter int unsigned ROWS  = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [ROWS*ROW_W-1:0] dats,
  input  logic                  ready,
  output logic                  valid,
  output logic [ROW_W-1:0]      datsOut,
  output logic [IDX_W-1:0]      rowIdx,
  output logic                  dendFlag,
  output logic                  busy,
  output logic                  doneFlag
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [ROWS*ROW_W-1:0]   shadow_q, shadow_d;
  logic                    done_q, done_d;

  logic                    send;
  logic                    xfer;
  logic                    last_row;

  assign send     = (state_q == StSend);
  assign xfer     = valid && ready;
  assign last_row = (cnt_q == IDX_W'(ROWS - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shadow_d = dats;
          cnt_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        // load is deliberately ignored here, including on the last-row edge.
        if (xfer) begin
          if (last_row) begin
            state_d  = StIdle;
            cnt_d    = '0;
            shadow_d = '0;
            done_d   = 1'b1;
          end else begin
            shadow_d = shadow_q >> ROW_W;
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The current row always sits in the low slice; the shadow shifts on transfer.
  assign valid    = send && enable;
  assign busy     = send;
  assign datsOut  = send ? shadow_q[ROW_W-1:0] : '0;
  assign rowIdx   = cnt_q;
  assign dendFlag = valid && last_row;
  assign doneFlag = done_q;

endmodule
